// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg
// Shared definitions for the data-memory responder: MMIO register offsets
// (word index within the 16-byte window), STATUS bit positions, the default
// MMIO window base and the address-decode region type.
package dmem_responder_pkg;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_0000;

    // Word index inside the MMIO window, taken from maddr[3:2]
    localparam logic [1:0] OFF_CYCLE  = 2'd0;
    localparam logic [1:0] OFF_LED    = 2'd1;
    localparam logic [1:0] OFF_CMP    = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    localparam int STATUS_TIMER_HIT = 0;
    localparam int STATUS_FAULT     = 1;

    typedef enum logic [1:0] {
        REGION_IDLE,
        REGION_RAM,
        REGION_MMIO,
        REGION_BAD
    } region_e;

endpackage

// File: rtl/dmem_responder_ram.sv
// dmem_responder_ram
// Word-wide data RAM with asynchronous read and synchronous write. Contents
// are deliberately not reset.
// Ports:
//   clk    in   1           rising-edge clock
//   we     in   1           write enable, commits at the rising edge
//   index  in   DEPTH_LOG2  word index shared by read and write
//   wdata  in   32          write data
//   rdata  out  32          read data, combinational (pre-write content)
module dmem_responder_ram #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] index,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[index] <= wdata;
        end
    end

    assign rdata = mem[index];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
// Target side of the pipeline M-stage memory port. Word RAM at the bottom of
// the address space plus a 16-byte MMIO window holding a free-running cycle
// counter, an LED register, a timer compare with sticky hit flag, and a
// sticky access-fault flag with the address of the first faulting access.
// Ports:
//   clk         in   1      rising-edge clock
//   reset       in   1      synchronous, active-high
//   maddr       in   32     byte address
//   mwdata      in   32     store data
//   DM_CS       in   1      chip select
//   DM_R        in   1      read strobe
//   DM_W        in   1      write strobe (full word)
//   mr_data     out  32     combinational read data
//   led_out     out  LED_W  LED register
//   irq         out  1      timer hit flag
//   fault       out  1      sticky fault flag
//   fault_addr  out  32     address of first fault since last clear
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT,
    parameter int          LED_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      maddr,
    input  logic [31:0]      mwdata,
    input  logic             DM_CS,
    input  logic             DM_R,
    input  logic             DM_W,
    output logic [31:0]      mr_data,
    output logic [LED_W-1:0] led_out,
    output logic             irq,
    output logic             fault,
    output logic [31:0]      fault_addr
);

    localparam logic [32:0] RAM_BYTES = 33'd4 << DEPTH_LOG2;

    logic [31:0] cycle_count;
    logic [31:0] cmp;
    logic        timer_hit;
    logic [31:0] ram_rdata;
    logic [31:0] status_word;
    logic [1:0]  mmio_reg;
    region_e     region;
    logic        faulting;
    logic        write_ok;
    logic        ram_we;
    logic        mmio_we;
    logic        status_we;

    assign mmio_reg = maddr[3:2];

    // Classify the current access; nothing is decoded without a strobe.
    always_comb begin
        region = REGION_IDLE;
        if (DM_CS && (DM_R || DM_W)) begin
            if ({1'b0, maddr} < RAM_BYTES) begin
                region = REGION_RAM;
            end else if (maddr[31:4] == MMIO_BASE[31:4]) begin
                region = REGION_MMIO;
            end else begin
                region = REGION_BAD;
            end
        end
    end

    assign faulting = (region != REGION_IDLE) &&
                      ((maddr[1:0] != 2'b00) || (region == REGION_BAD));

    // A write landing in the same cycle as reset is dropped everywhere,
    // including the un-reset RAM.
    assign write_ok  = DM_CS && DM_W && !faulting && !reset;
    assign ram_we    = write_ok && (region == REGION_RAM);
    assign mmio_we   = write_ok && (region == REGION_MMIO);
    assign status_we = mmio_we && (mmio_reg == OFF_STATUS);

    dmem_responder_ram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .index(maddr[DEPTH_LOG2+1:2]),
        .wdata(mwdata),
        .rdata(ram_rdata)
    );

    always_comb begin
        status_word                   = '0;
        status_word[STATUS_TIMER_HIT] = timer_hit;
        status_word[STATUS_FAULT]     = fault;
    end

    // Read mux: zero whenever there is no valid, non-faulting read.
    always_comb begin
        mr_data = '0;
        if (DM_CS && DM_R && !faulting) begin
            case (region)
                REGION_RAM: mr_data = ram_rdata;
                REGION_MMIO: begin
                    case (mmio_reg)
                        OFF_CYCLE:  mr_data = cycle_count;
                        OFF_LED:    mr_data = 32'(led_out);
                        OFF_CMP:    mr_data = cmp;
                        OFF_STATUS: mr_data = status_word;
                        default:    mr_data = '0;
                    endcase
                end
                default: mr_data = '0;
            endcase
        end
    end

    // MMIO registers. Sticky flags give set priority over a W1C clear, and
    // the timer compare always sees the CMP value from before any write.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count <= '0;
            led_out     <= '0;
            cmp         <= '0;
            timer_hit   <= 1'b0;
            fault       <= 1'b0;
            fault_addr  <= '0;
        end else begin
            cycle_count <= cycle_count + 32'd1;
            if (mmio_we && (mmio_reg == OFF_LED)) begin
                led_out <= mwdata[LED_W-1:0];
            end
            if (mmio_we && (mmio_reg == OFF_CMP)) begin
                cmp <= mwdata;
            end
            if ((cmp != 32'd0) && (cycle_count == cmp)) begin
                timer_hit <= 1'b1;
            end else if (status_we && mwdata[STATUS_TIMER_HIT]) begin
                timer_hit <= 1'b0;
            end
            if (faulting) begin
                fault <= 1'b1;
                if (!fault) begin
                    fault_addr <= maddr;
                end
            end else if (status_we && mwdata[STATUS_FAULT]) begin
                fault <= 1'b0;
            end
        end
    end

    assign irq = timer_hit;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
// Self-checking bench for dmem_responder: a vector table for single-cycle
// accesses, then hand sequences for reset, the cycle counter and the timer.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic        DM_CS;
    logic        DM_R;
    logic        DM_W;
    logic [31:0] mr_data;
    logic [15:0] led_out;
    logic        irq;
    logic        fault;
    logic [31:0] fault_addr;

    int          checks   = 0;
    int          failures = 0;
    int          model_cycle = 0;
    logic [31:0] rd_queue[$];

    typedef struct {
        bit          cs;
        bit          r;
        bit          w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        bit          exp_fault;
        logic [31:0] exp_faddr;
        logic [15:0] exp_led;
        string       name;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    // Independent count of cycles since the last sampled reset
    always @(posedge clk) begin
        if (reset) model_cycle <= 0;
        else       model_cycle <= model_cycle + 1;
    end

    dmem_responder dut (
        .clk       (clk),
        .reset     (reset),
        .maddr     (maddr),
        .mwdata    (mwdata),
        .DM_CS     (DM_CS),
        .DM_R      (DM_R),
        .DM_W      (DM_W),
        .mr_data   (mr_data),
        .led_out   (led_out),
        .irq       (irq),
        .fault     (fault),
        .fault_addr(fault_addr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_output(input string name);
        logic [31:0] exp;
        if (rd_queue.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s scoreboard empty actual=%h", name, mr_data);
        end else begin
            exp = rd_queue.pop_front();
            check({name, ".rd"}, mr_data, exp);
        end
    endtask

    // Drive one access for one cycle; mr_data is checked mid-cycle, and the
    // task returns just after the edge so registered outputs can be checked.
    task automatic apply_stimulus(input bit cs, input bit r, input bit w,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] exp_rd, input string name);
        @(negedge clk);
        DM_CS  = cs;
        DM_R   = r;
        DM_W   = w;
        maddr  = addr;
        mwdata = wdata;
        rd_queue.push_back(exp_rd);
        #1;
        check_output(name);
        @(posedge clk);
        #1;
        DM_CS = 1'b0;
        DM_R  = 1'b0;
        DM_W  = 1'b0;
    endtask

    function automatic void add_vec(bit cs, bit r, bit w, logic [31:0] addr, logic [31:0] wdata,
                                    logic [31:0] exp_rd, bit exp_fault, logic [31:0] exp_faddr,
                                    logic [15:0] exp_led, string name);
        vec_t v;
        v.cs = cs; v.r = r; v.w = w; v.addr = addr; v.wdata = wdata;
        v.exp_rd = exp_rd; v.exp_fault = exp_fault; v.exp_faddr = exp_faddr;
        v.exp_led = exp_led; v.name = name;
        vecs.push_back(v);
    endfunction

    // Reset sequence; optionally drives a RAM write alongside reset.
    task automatic do_reset(input bit with_write);
        @(negedge clk);
        reset = 1'b1;
        if (with_write) begin
            DM_CS = 1'b1; DM_W = 1'b1; DM_R = 1'b0;
            maddr = 32'h10; mwdata = 32'h0000_0BAD;
        end
        @(posedge clk);
        #1;
        DM_CS = 1'b0; DM_W = 1'b0; DM_R = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".fault"}, 32'(fault), 32'd0);
        check({tag, ".faddr"}, fault_addr, 32'd0);
        check({tag, ".led"}, 32'(led_out), 32'd0);
        check({tag, ".irq"}, 32'(irq), 32'd0);
    endtask

    initial begin
        bit done;
        reset = 1'b1; DM_CS = 1'b0; DM_R = 1'b0; DM_W = 1'b0;
        maddr = '0; mwdata = '0;

        //          cs r w addr           wdata          exp_rd         flt faddr          led
        add_vec(1, 0, 1, 32'h10,        32'hDEADBEEF, 32'h0,        0, 32'h0,        16'h0,    "wr_10");
        add_vec(1, 1, 0, 32'h10,        32'h0,        32'hDEADBEEF, 0, 32'h0,        16'h0,    "rd_10");
        add_vec(1, 1, 1, 32'h10,        32'h1,        32'hDEADBEEF, 0, 32'h0,        16'h0,    "rw_10");
        add_vec(1, 1, 0, 32'h10,        32'h0,        32'h1,        0, 32'h0,        16'h0,    "rd_10_new");
        add_vec(1, 0, 1, 32'h12,        32'h55,       32'h0,        1, 32'h12,       16'h0,    "wr_misalign");
        add_vec(1, 1, 0, 32'h10,        32'h0,        32'h1,        1, 32'h12,       16'h0,    "rd_10_kept");
        add_vec(1, 1, 0, 32'h9000_0000, 32'h0,        32'h0,        1, 32'h12,       16'h0,    "rd_oor_sticky");
        add_vec(1, 0, 1, 32'hFFFF_000C, 32'h2,        32'h0,        0, 32'h12,       16'h0,    "w1c_fault");
        add_vec(1, 1, 0, 32'h9000_0000, 32'h0,        32'h0,        1, 32'h9000_0000,16'h0,    "rd_oor_new");
        add_vec(1, 0, 1, 32'hFFFF_0004, 32'hFFFF_A5A5,32'h0,        1, 32'h9000_0000,16'hA5A5, "wr_led");
        add_vec(1, 1, 0, 32'hFFFF_0004, 32'h0,        32'h0000_A5A5,1, 32'h9000_0000,16'hA5A5, "rd_led");
        add_vec(0, 1, 1, 32'hFFFF_0004, 32'h1234,     32'h0,        1, 32'h9000_0000,16'hA5A5, "cs_low");
        add_vec(1, 1, 0, 32'hFFFF_000C, 32'h0,        32'h2,        1, 32'h9000_0000,16'hA5A5, "rd_status");
        add_vec(1, 0, 1, 32'hFFC,       32'hCAFE0001, 32'h0,        1, 32'h9000_0000,16'hA5A5, "wr_top");
        add_vec(1, 1, 0, 32'hFFC,       32'h0,        32'hCAFE0001, 1, 32'h9000_0000,16'hA5A5, "rd_top");
        add_vec(1, 1, 0, 32'h1000,      32'h0,        32'h0,        1, 32'h9000_0000,16'hA5A5, "rd_past_top");
        add_vec(1, 0, 1, 32'hFFFF_000C, 32'h3,        32'h0,        0, 32'h9000_0000,16'hA5A5, "w1c_both");
        add_vec(1, 1, 0, 32'h1000,      32'h0,        32'h0,        1, 32'h1000,     16'hA5A5, "rd_past_top_new");
        add_vec(1, 0, 1, 32'hFFFF_000C, 32'h2,        32'h0,        0, 32'h1000,     16'hA5A5, "w1c_fault2");
        add_vec(1, 0, 0, 32'h1000,      32'h0,        32'h0,        0, 32'h1000,     16'hA5A5, "no_strobe");
        add_vec(1, 1, 0, 32'hFFFF_0010, 32'h0,        32'h0,        1, 32'hFFFF_0010,16'hA5A5, "rd_past_mmio");
        add_vec(1, 0, 1, 32'hFFFF_0008, 32'h7,        32'h0,        1, 32'hFFFF_0010,16'hA5A5, "wr_cmp");
        add_vec(1, 1, 0, 32'hFFFF_0008, 32'h0,        32'h7,        1, 32'hFFFF_0010,16'hA5A5, "rd_cmp");
        add_vec(1, 1, 0, 32'hFFFF_0006, 32'h0,        32'h0,        1, 32'hFFFF_0010,16'hA5A5, "rd_mmio_misalign");

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_state("reset0");

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].cs, vecs[i].r, vecs[i].w, vecs[i].addr, vecs[i].wdata,
                           vecs[i].exp_rd, vecs[i].name);
            check({vecs[i].name, ".fault"}, 32'(fault), 32'(vecs[i].exp_fault));
            check({vecs[i].name, ".faddr"}, fault_addr, vecs[i].exp_faddr);
            check({vecs[i].name, ".led"}, 32'(led_out), 32'(vecs[i].exp_led));
        end

        // Reset with a concurrent RAM write: the write must be dropped
        do_reset(1'b1);
        #1;
        check_reset_state("reset_mid");

        // CMP is 0 after reset while the counter passes through 0: no hit
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check("irq_cmp_zero", 32'(irq), 32'd0);
        end
        apply_stimulus(1, 1, 0, 32'hFFFF_0000, 32'h0, 32'd20, "cycle_20");
        apply_stimulus(1, 0, 1, 32'hFFFF_0000, 32'h0, 32'h0, "wr_cycle");
        check("wr_cycle.fault", 32'(fault), 32'd0);
        apply_stimulus(1, 1, 0, 32'hFFFF_0000, 32'h0, 32'd22, "cycle_22");
        apply_stimulus(1, 1, 0, 32'h10, 32'h0, 32'h1, "rd_10_after_reset");

        // Timer compare at 50, hit visible once the counter reaches 51
        apply_stimulus(1, 0, 1, 32'hFFFF_0008, 32'd50, 32'h0, "wr_cmp50");
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(posedge clk);
            #1;
            check("irq_timer", 32'(irq), 32'(model_cycle >= 51));
            if (model_cycle >= 54) done = 1'b1;
        end
        if (!done) check("timer_budget", 32'(model_cycle), 32'd54);
        apply_stimulus(1, 1, 0, 32'hFFFF_000C, 32'h0, 32'h1, "status_hit");
        apply_stimulus(1, 0, 1, 32'hFFFF_000C, 32'h1, 32'h0, "w1c_hit");
        check("w1c_hit.irq", 32'(irq), 32'd0);
        apply_stimulus(1, 0, 1, 32'hFFFF_0008, 32'h0, 32'h0, "cmp_off");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("irq_off", 32'(irq), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
